multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control sequencer: replaces per-opcode one-shot decode with an FSM that steps
//  one instruction through FETCH/DECODE/EXEC/MEM/WB over shared ALU, memory and register file.
//  Supports R-type(000000), lw(100011), sw(101011), beq(000100), j(000010); stalls on memory ready.
//  Sits between the instruction register opcode field and the multi-cycle datapath muxes/enables.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting on mem_ready before fault (0 = wait forever)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      reset, synchronous, active-low
//  run          in   1      start/continue execution from S_IDLE
//  opcode       in   6      IR[31:26], valid from DECODE onward
//  mem_ready    in   1      memory completes current mem_read/mem_write this cycle
//  pc_write     out  1      unconditional PC load
//  pc_write_cond out 1      PC load if ALU zero (beq)
//  iord         out  1      0: mem addr = PC, 1: mem addr = ALUOut
//  mem_read     out  1      memory read request
//  mem_write    out  1      memory write request
//  ir_write     out  1      latch instruction register
//  mem_to_reg   out  1      write-back data = MDR
//  reg_dst      out  1      dest = rd (1) / rt (0)
//  reg_write    out  1      register file write enable
//  alu_src_a    out  1      0: PC, 1: rs
//  alu_src_b    out  2      00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
//  alu_op       out  2      00 add, 01 sub, 10 funct-decoded
//  pc_source    out  2      00 ALU result, 01 ALUOut, 10 jump target
//  halted       out  1      sticky: illegal opcode or memory timeout
//  fault_code   out  2      00 none, 01 illegal opcode, 10 mem timeout
//  retired      out  CNT_W  instructions completed since reset (wraps)
// BEHAVIOUR
//  - State register only; all control outputs Moore-decoded from state (mem_ready gates ir_write).
//  - Reset (rst_n=0 at edge): state=S_IDLE, retired=0, halted=0, fault_code=0, wait cnt=0;
//    every control output 0 in S_IDLE.
//  - S_IDLE -> S_FETCH when run=1, else stay.
//  - S_FETCH: mem_read=1,iord=0,alu_src_a=0,alu_src_b=01,alu_op=00,pc_source=00;
//    ir_write=pc_write=mem_ready. Stay until mem_ready, then -> S_DECODE.
//  - S_DECODE: alu_src_a=0,alu_src_b=11,alu_op=00 (branch target to ALUOut). Next by opcode:
//    lw/sw -> S_MEMADR; R-type -> S_EXEC; beq -> S_BRANCH; j -> S_JUMP; other -> S_FAULT (code 01).
//  - S_MEMADR: alu_src_a=1,alu_src_b=10,alu_op=00; lw -> S_MEMRD, sw -> S_MEMWR.
//  - S_MEMRD: mem_read=1,iord=1; wait mem_ready -> S_MEMWB.
//  - S_MEMWB: reg_write=1,mem_to_reg=1,reg_dst=0; retire.
//  - S_MEMWR: mem_write=1,iord=1; wait mem_ready; retire on mem_ready.
//  - S_EXEC: alu_src_a=1,alu_src_b=00,alu_op=10 -> S_ALUWB.
//  - S_ALUWB: reg_write=1,reg_dst=1,mem_to_reg=0; retire.
//  - S_BRANCH: alu_src_a=1,alu_src_b=00,alu_op=01,pc_write_cond=1,pc_source=01; retire.
//  - S_JUMP: pc_write=1,pc_source=10; retire.
//  - Retire: retired+=1 (mod 2^CNT_W), next state S_FETCH if run=1 else S_IDLE.
//  - Latency: lw 5 cycles, sw/R-type 4, beq/j 3, plus one per mem_ready-low cycle.
//  - Timeout: wait cnt counts consecutive mem_ready=0 cycles in FETCH/MEMRD/MEMWR, clears on
//    state change; reaching MEM_TIMEOUT -> S_FAULT, code 10. Disabled when MEM_TIMEOUT=0.
//  - S_FAULT: all controls 0, halted=1, fault_code held; exit only via reset (run ignored).
//  - run deasserted mid-instruction: instruction completes; checked only at retire/S_IDLE.
//  - Reset mid-operation overrides everything, incl. pending memory access; no write issued next cycle.
// STRUCTURE
//  - Shared package mips_pkg: opcode constants (OP_RTYPE,OP_LW,OP_SW,OP_BEQ,OP_J), state enum,
//    alu_op/alu_src_b/pc_source encodings, fault codes.
//  - One sub-module natural: mc_ctrl_decode (pure combinational state -> control-word table).
//  - Top keeps state register, next-state logic, timeout counter, retire counter.
// TESTING
//  1 reset held 3 cycles, run=0 -> all outputs 0, retired=0, state S_IDLE stays.
//  2 run=1, mem_ready=1, opcode=100011 -> mem_read/iord sequence, reg_write+mem_to_reg in cycle 5,
//    retired=1, back in S_FETCH.
//  3 op sequence 000000,101011,000100,000010 with mem_ready=1 -> 4,4,3,3 cycles; retired=4;
//    pc_write_cond only in beq cycle 3, pc_source=10 only in j cycle 3.
//  4 lw with mem_ready low 3 cycles in FETCH and 2 in MEMRD -> 10 cycles total, ir_write exactly once.
//  5 opcode=111111 -> S_FAULT after DECODE, halted=1, fault_code=01, no reg_write/mem_write ever.
//  6 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> halted=1, fault_code=10 after 4 wait cycles;
//    rst_n=0 one edge -> all cleared; also rst_n pulse during S_MEMWR -> mem_write 0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath mux selects, fault codes and the control word driven to the datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_FAULT
    } state_t;

    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
    typedef enum logic [1:0] {SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} alu_src_b_t;
    typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10} pc_src_t;
    typedef enum logic [1:0] {FC_NONE = 2'b00, FC_ILLEGAL = 2'b01, FC_TIMEOUT = 2'b10} fault_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_src_t    pc_source;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Pure combinational state -> control word table. Only FETCH looks at
// mem_ready, so the IR and PC update exactly once per fetched instruction.
module mc_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCS_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: state register, next-state logic, memory-wait
// timeout and retired-instruction counter; control word decoded from state.
module multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             halted,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             state_q, state_d;
    fault_t             fault_q, fault_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               halted_q;
    logic               stall, retire;
    ctrl_t              ctrl;

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        wait_d    = '0;
        retired_d = retired_q;
        stall     = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE; else stall = 1'b1;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FAULT;
                        fault_d = FC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB; else stall = 1'b1;
            S_MEMWR:  if (mem_ready) retire = 1'b1; else stall = 1'b1;
            S_EXEC:   state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: retire = 1'b1;
            default:  state_d = state_q;
        endcase

        // wait_q counts stall cycles already spent; the MEM_TIMEOUT-th one faults
        if (stall && MEM_TIMEOUT != 0) begin
            if (int'(wait_q) >= MEM_TIMEOUT - 1) begin
                state_d = S_FAULT;
                fault_d = FC_TIMEOUT;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end

        if (retire) begin
            retired_d = retired_q + 1'b1;
            state_d   = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            fault_q   <= FC_NONE;
            wait_q    <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            halted_q  <= (state_d == S_FAULT);
        end
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign halted        = halted_q;
    assign fault_code    = fault_q;
    assign retired       = retired_q;

endmodule
